matmult_nxn_seq: RTL and testbench

// - Parametrised NxN integer matrix multiplier, C = A x B; next generation of the fixed 2x2 MAC multiplier.
// - Uses N parallel MAC lanes that compute one row of C per N cycles, so one matrix takes N*N compute cycles.
// - Sits between the operand buffers and the result writeback stage.
// - Valid/ready handshakes on input and output replace the free-running 2x2 datapath.

---
 rtl/matmult_nxn_seq_if.sv | 43 ++++
 rtl/matmult_nxn_seq.sv | 179 +++++++++++++++++
 tb/tb_matmult_nxn_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmult_nxn_seq_if.sv
// matmult_nxn_seq_if
// Handshake and data bundle for the NxN sequential matrix multiplier.
//   in_valid/in_ready      : operand handshake (producer -> multiplier)
//   a_flat/b_flat          : A and B, element (i,j) at [(i*N+j)*DATA_W +: DATA_W]
//   acc_en                 : accumulate request, present only with MATMULT_ACCUM_EN
//   busy                   : a job is in progress
//   out_valid/out_ready    : result handshake (multiplier -> consumer)
//   c_flat                 : C, element (i,j) at [(i*N+j)*ACC_W +: ACC_W]
// Modports: master = operand producer / result consumer, slave = multiplier.
// Optional feature macro: MATMULT_ACCUM_EN.
interface matmult_nxn_seq_if #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*N*DATA_W-1:0]   a_flat;
    logic [N*N*DATA_W-1:0]   b_flat;
`ifdef MATMULT_ACCUM_EN
    logic                    acc_en;
`endif
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*N*ACC_W-1:0]    c_flat;

    modport master (
`ifdef MATMULT_ACCUM_EN
        output acc_en,
`endif
        output in_valid, a_flat, b_flat, out_ready,
        input  in_ready, busy, out_valid, c_flat
    );

    modport slave (
`ifdef MATMULT_ACCUM_EN
        input  acc_en,
`endif
        input  in_valid, a_flat, b_flat, out_ready,
        output in_ready, busy, out_valid, c_flat
    );
endinterface

// File: rtl/matmult_nxn_seq.sv
// matmult_nxn_seq
// Sequential NxN integer matrix multiplier, C = A x B.
// N parallel MAC lanes (one per column j) walk row i and inner index k;
// one row of C completes every N cycles, a full matrix in N*N cycles.
// Ports:
//   clk  : clock, all logic on rising edge
//   rst  : synchronous active-high reset, aborts any job and clears C
//   bus  : matmult_nxn_seq_if.slave (operand/result handshakes, A, B, C, busy)
// Parameters: N (>=2), DATA_W, ACC_W (result width, wraps if set narrow),
//   SIGNED (1: two's-complement, 0: unsigned).
// Optional feature macro: MATMULT_ACCUM_EN adds bus.acc_en; when set at
//   accept, each lane seeds its row from the current C so C_new = C_old + A x B.
module matmult_nxn_seq #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    matmult_nxn_seq_if.slave   bus
);
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N * N);
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [N*N*DATA_W-1:0]   a_reg;
    logic [N*N*DATA_W-1:0]   b_reg;
    logic [CW-1:0]           row_reg;
    logic [CW-1:0]           k_reg;
    logic                    acc_mode_reg;
    logic [ACC_W-1:0]        acc_reg  [N];
    logic [ACC_W-1:0]        c_reg    [N*N];
    logic [ACC_W-1:0]        lane_sum [N];

    logic accept;
    logic last_k;
    logic last_row;
    logic acc_req;

    assign accept   = (state_reg == IDLE) && bus.in_valid;
    assign last_k   = (k_reg == CW'(N - 1));
    assign last_row = (row_reg == CW'(N - 1));

`ifdef MATMULT_ACCUM_EN
    assign acc_req = bus.acc_en;
`else
    assign acc_req = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = COMPUTE;
            COMPUTE: if (last_k && last_row) state_next = DONE;
            // A pending result blocks new jobs even if out_ready and
            // in_valid coincide; the next accept is one edge later.
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- MAC lanes ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_W-1:0] a_el;
            logic [DATA_W-1:0] b_el;
            logic [PW-1:0]     prod;
            logic [ACC_W-1:0]  prod_acc;
            logic [ACC_W-1:0]  base;
            logic [IW-1:0]     c_idx;

            assign a_el  = a_reg[(int'(row_reg) * N + int'(k_reg)) * DATA_W +: DATA_W];
            assign b_el  = b_reg[(int'(k_reg) * N + gi) * DATA_W +: DATA_W];
            assign c_idx = IW'(int'(row_reg) * N + gi);

            if (SIGNED != 0) begin : g_signed
                logic signed [PW-1:0] a_ext;
                logic signed [PW-1:0] b_ext;
                assign a_ext = PW'($signed(a_el));
                assign b_ext = PW'($signed(b_el));
                assign prod  = a_ext * b_ext;
            end else begin : g_unsigned
                assign prod = PW'(a_el) * PW'(b_el);
            end

            // Extend the full-width product to ACC_W, or keep its low bits
            // when ACC_W is narrower (modulo 2^ACC_W arithmetic).
            if (ACC_W >= PW) begin : g_ext
                if (SIGNED != 0) begin : g_sext
                    assign prod_acc = ACC_W'($signed(prod));
                end else begin : g_zext
                    assign prod_acc = ACC_W'(prod);
                end
            end else begin : g_trunc
                assign prod_acc = prod[ACC_W-1:0];
            end

            // At k==0 the running sum restarts from 0 (or from the current
            // C(i,j) in accumulate mode) instead of the previous row's total.
            assign base = (k_reg == '0) ? (acc_mode_reg ? c_reg[c_idx] : '0)
                                        : acc_reg[gi];
            assign lane_sum[gi] = base + prod_acc;
        end
    endgenerate

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            row_reg      <= '0;
            k_reg        <= '0;
            acc_mode_reg <= 1'b0;
            for (int j = 0; j < N; j++) begin
                acc_reg[j] <= '0;
            end
            for (int e = 0; e < N * N; e++) begin
                c_reg[e] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg        <= bus.a_flat;
                        b_reg        <= bus.b_flat;
                        row_reg      <= '0;
                        k_reg        <= '0;
                        acc_mode_reg <= acc_req;
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < N; j++) begin
                        acc_reg[j] <= lane_sum[j];
                    end
                    if (last_k) begin
                        for (int j = 0; j < N; j++) begin
                            c_reg[IW'(int'(row_reg) * N + j)] <= lane_sum[j];
                        end
                        k_reg   <= '0;
                        row_reg <= last_row ? '0 : row_reg + 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = (state_reg == DONE);

    generate
        for (gi = 0; gi < N * N; gi++) begin : g_cout
            assign bus.c_flat[gi*ACC_W +: ACC_W] = c_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_matmult_nxn_seq.sv
// tb_matmult_nxn_seq
// Scoreboard bench for matmult_nxn_seq: expected results are queued when a
// job is issued; per-DUT monitors pop and compare on each result handshake.
// DUTs: d0 = N2 unsigned (ACC_W 33), d1 = N2 signed (ACC_W 33), d2 = N4 unsigned.
// Honours MATMULT_ACCUM_EN when defined.
module tb_matmult_nxn_seq;
    typedef logic [543:0] wide_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wide_t q_u [$];
    wide_t q_s [$];
    wide_t q_4 [$];

    matmult_nxn_seq_if #(.N(2), .DATA_W(16), .ACC_W(33)) bus_u ();
    matmult_nxn_seq_if #(.N(2), .DATA_W(16), .ACC_W(33)) bus_s ();
    matmult_nxn_seq_if #(.N(4), .DATA_W(16), .ACC_W(34)) bus_4 ();

    matmult_nxn_seq #(.N(2), .DATA_W(16), .ACC_W(33), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .bus(bus_u));
    matmult_nxn_seq #(.N(2), .DATA_W(16), .ACC_W(33), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s));
    matmult_nxn_seq #(.N(4), .DATA_W(16), .ACC_W(34), .SIGNED(0)) dut_4 (
        .clk(clk), .rst(rst), .bus(bus_4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input wide_t got, input wide_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Pack four 2x2 elements (row-major) into w-bit fields.
    function automatic wide_t mk4(input int w, input longint v0, input longint v1,
                                  input longint v2, input longint v3);
        wide_t mask;
        wide_t r;
        mask = (wide_t'(1) << w) - 1;
        r = (wide_t'(v0) & mask)
          | ((wide_t'(v1) & mask) << w)
          | ((wide_t'(v2) & mask) << (2 * w))
          | ((wide_t'(v3) & mask) << (3 * w));
        return r;
    endfunction

    task automatic set_in(input int d, input logic v, input wide_t a, input wide_t b,
                          input logic acc);
        case (d)
            0: begin bus_u.in_valid = v; bus_u.a_flat = a[63:0];  bus_u.b_flat = b[63:0];  end
            1: begin bus_s.in_valid = v; bus_s.a_flat = a[63:0];  bus_s.b_flat = b[63:0];  end
            default: begin bus_4.in_valid = v; bus_4.a_flat = a[255:0]; bus_4.b_flat = b[255:0]; end
        endcase
`ifdef MATMULT_ACCUM_EN
        case (d)
            0: bus_u.acc_en = acc;
            1: bus_s.acc_en = acc;
            default: bus_4.acc_en = acc;
        endcase
`else
        if (acc) $display("note: acc_en ignored in this build");
`endif
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus_u.in_ready : (d == 1) ? bus_s.in_ready : bus_4.in_ready;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? bus_u.out_valid : (d == 1) ? bus_s.out_valid : bus_4.out_valid;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? bus_u.busy : (d == 1) ? bus_s.busy : bus_4.busy;
    endfunction
    function automatic wide_t get_c(input int d);
        return (d == 0) ? wide_t'(bus_u.c_flat) : (d == 1) ? wide_t'(bus_s.c_flat)
                                                           : wide_t'(bus_4.c_flat);
    endfunction

    // Called at posedge+1. Returns after the accept edge (at edge+1), with
    // the number of cycles spent waiting for in_ready.
    task automatic send(input int d, input wide_t a, input wide_t b, input logic acc,
                        output int waited);
        waited = 0;
        set_in(d, 1'b1, a, b, acc);
        while (!get_ready(d) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_d%0d: got in_ready=0 required in_ready=1", d);
        end
        @(posedge clk); #1;
        // Scramble the inputs: the job must have been captured at the accept edge.
        set_in(d, 1'b0, ~a, ~b, ~acc);
        $display("d%0d job accepted at %0t", d, $time);
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!get_valid(d) && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!get_ready(d) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("idle_timeout", wide_t'(get_ready(d)), 1);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && bus_u.out_valid && bus_u.out_ready) begin
            if (q_u.size() == 0) check("d0_unexpected_result", wide_t'(bus_u.c_flat), 0);
            else check("d0_result", wide_t'(bus_u.c_flat), q_u.pop_front());
            $display("d0 result %0h at %0t", bus_u.c_flat, $time);
        end
    end
    always @(negedge clk) begin
        if (!rst && bus_s.out_valid && bus_s.out_ready) begin
            if (q_s.size() == 0) check("d1_unexpected_result", wide_t'(bus_s.c_flat), 0);
            else check("d1_result", wide_t'(bus_s.c_flat), q_s.pop_front());
            $display("d1 result %0h at %0t", bus_s.c_flat, $time);
        end
    end
    always @(negedge clk) begin
        if (!rst && bus_4.out_valid && bus_4.out_ready) begin
            if (q_4.size() == 0) check("d2_unexpected_result", wide_t'(bus_4.c_flat), 0);
            else check("d2_result", wide_t'(bus_4.c_flat), q_4.pop_front());
            $display("d2 result %0h at %0t", bus_4.c_flat, $time);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        wide_t a1, b1, c1, a2, b2, c2, ones, a4, b4, c4;
        int    lat;
        int    waited;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, '0, '0, 1'b0);
        bus_u.out_ready = 1'b1;
        bus_s.out_ready = 1'b1;
        bus_4.out_ready = 1'b1;

        a1 = mk4(16, 1, 2, 3, 4);
        b1 = mk4(16, 5, 6, 7, 8);
        c1 = mk4(33, 19, 22, 43, 50);
        a2 = mk4(16, 2, 1, 0, 3);
        b2 = mk4(16, 1, 2, 3, 4);
        c2 = mk4(33, 5, 8, 9, 12);
        ones = mk4(16, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready",  wide_t'(get_ready(0)), 1);
        check("rst_busy",      wide_t'(get_busy(0)), 0);
        check("rst_out_valid", wide_t'(get_valid(0)), 0);
        check("rst_c_flat",    get_c(0), 0);
        check("rst_c_flat_n4", get_c(2), 0);

        // Test 1: basic job, latency, turnaround
        q_u.push_back(c1);
        send(0, a1, b1, 1'b0, waited);
        check("t1_busy", wide_t'(get_busy(0)), 1);
        wait_valid(0, lat);
        check("t1_latency", wide_t'(lat), 4);
        check("t1_in_ready_in_done", wide_t'(get_ready(0)), 0);
        @(posedge clk); #1;
        check("t1_out_valid_drop", wide_t'(get_valid(0)), 0);
        check("t1_in_ready_back", wide_t'(get_ready(0)), 1);
        // Next job accepted at the following edge: 2 edges after out_valid.
        q_u.push_back(c2);
        send(0, a2, b2, 1'b0, waited);
        check("t1_back_to_back_wait", wide_t'(waited), 0);
        wait_valid(0, lat);
        check("t1b_latency", wide_t'(lat), 4);
        wait_idle(0);

        // Test 2: full-scale operands, unsigned and signed
        q_u.push_back(mk4(33, 'h1FFFC0002, 'h1FFFC0002, 'h1FFFC0002, 'h1FFFC0002));
        send(0, ones, ones, 1'b0, waited);
        q_s.push_back(mk4(33, 2, 2, 2, 2));
        send(1, ones, ones, 1'b0, waited);
        wait_valid(0, lat); wait_idle(0);
        wait_valid(1, lat); wait_idle(1);
        q_s.push_back(mk4(33, 9, 10, -13, -14));
        send(1, mk4(16, -1, 2, 3, -4), b1, 1'b0, waited);
        wait_valid(1, lat);
        check("t2_signed_latency", wide_t'(lat), 4);
        wait_idle(1);

        // Test 3: backpressure
        bus_u.out_ready = 1'b0;
        q_u.push_back(c1);
        send(0, a1, b1, 1'b0, waited);
        wait_valid(0, lat);
        set_in(0, 1'b1, a2, b2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("t3_hold_out_valid", wide_t'(get_valid(0)), 1);
            check("t3_hold_c_flat", get_c(0), c1);
            check("t3_hold_in_ready", wide_t'(get_ready(0)), 0);
            @(posedge clk); #1;
        end
        q_u.push_back(c2);
        bus_u.out_ready = 1'b1;
        send(0, a2, b2, 1'b0, waited);
        check("t3_accept_after_release", wide_t'(waited), 1);
        wait_valid(0, lat);
        wait_idle(0);

        // Test 4: reset during the second compute cycle
        send(0, a1, b1, 1'b0, waited);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_out_valid", wide_t'(get_valid(0)), 0);
        check("t4_busy",      wide_t'(get_busy(0)), 0);
        check("t4_c_flat",    get_c(0), 0);
        check("t4_in_ready",  wide_t'(get_ready(0)), 1);
        repeat (6) @(posedge clk);
        #1;
        check("t4_no_result_after_abort", wide_t'(get_valid(0)), 0);
        q_u.push_back(c1);
        send(0, a1, b1, 1'b0, waited);
        wait_valid(0, lat);
        wait_idle(0);

`ifdef MATMULT_ACCUM_EN
        // Test 5: accumulate mode
        q_u.push_back(c1);
        send(0, a1, b1, 1'b0, waited);
        wait_valid(0, lat); wait_idle(0);
        q_u.push_back(mk4(33, 38, 44, 86, 100));
        send(0, a1, b1, 1'b1, waited);
        wait_valid(0, lat); wait_idle(0);
        q_u.push_back(c1);
        send(0, a1, b1, 1'b0, waited);
        wait_valid(0, lat); wait_idle(0);
`endif

        // Test 6: N=4 identity and all-ones
        a4 = '0; b4 = '0; c4 = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a4[(i*4+j)*16 +: 16] = (i == j) ? 16'd1 : 16'd0;
                b4[(i*4+j)*16 +: 16] = 16'(i * 4 + j);
                c4[(i*4+j)*34 +: 34] = 34'(i * 4 + j);
            end
        end
        q_4.push_back(c4);
        send(2, a4, b4, 1'b0, waited);
        wait_valid(2, lat);
        check("t6_identity_latency", wide_t'(lat), 16);
        wait_idle(2);
        a4 = '0; c4 = '0;
        for (int e = 0; e < 16; e++) begin
            a4[e*16 +: 16] = 16'd1;
            c4[e*34 +: 34] = 34'd4;
        end
        q_4.push_back(c4);
        send(2, a4, a4, 1'b0, waited);
        wait_valid(2, lat);
        check("t6_ones_latency", wide_t'(lat), 16);
        wait_idle(2);

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_d0", wide_t'(q_u.size()), 0);
        check("end_queue_d1", wide_t'(q_s.size()), 0);
        check("end_queue_d2", wide_t'(q_4.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
